// File: rtl/pmodclp_lcd_driver.sv
// Purpose: drives an HD44780-style parallel LCD bus from byte commands and runs power-up init first.
// Latency: a byte reaches DB/RS one edge after accept; E pulses T_SETUP edges later.
// Backpressure: cmd_ready is high only in IDLE, for one byte per full write plus execution wait.
module pmodclp_lcd_driver #(
    parameter int T_POWERUP   = 1_000_000,
    parameter int T_SETUP     = 3,
    parameter int T_EPULSE    = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EPULSE, T_HOLD)),
                                max2(T_EXEC, T_EXEC_LONG));
    localparam int CW    = $clog2(T_MAX + 1);

    // Each state lasts N cycles: the counter is loaded with N-1 on entry and the
    // state is left on the edge where it reads zero.
    localparam logic [CW-1:0] LD_PWRUP  = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EPULSE = CW'(T_EPULSE - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC   = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG   = CW'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        PWRUP_WAIT,
        INIT_LOAD,
        SETUP,
        EPULSE,
        HOLD,
        EXEC_WAIT,
        IDLE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic          init_done_q;
    logic          ready_q;
    logic          rs_q;
    logic          e_q;
    logic [7:0]    db_q;

    logic          cnt_zero;
    logic          long_exec;

    // Init sequence: function set 8-bit/2-line, display on, clear, entry mode increment.
    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    assign cnt_zero  = (cnt_q == '0);
    // Clear and Home need the long execution time; data writes never do.
    assign long_exec = !rs_q && (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03);

    assign cmd_ready = ready_q;
    assign init_done = init_done_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_db    = db_q;

    // Write sequencer: power-up wait, init ROM playback, then host bytes, all through one strobe path.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            // Reset is the PWRUP_WAIT entry, so the power-up count is loaded here.
            state_q     <= PWRUP_WAIT;
            cnt_q       <= LD_PWRUP;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            db_q        <= 8'h00;
        end else begin
            case (state_q)
                PWRUP_WAIT: begin
                    if (cnt_zero) begin
                        state_q <= INIT_LOAD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                INIT_LOAD: begin
                    rs_q    <= 1'b0;
                    db_q    <= init_rom(idx_q);
                    state_q <= SETUP;
                    cnt_q   <= LD_SETUP;
                end
                SETUP: begin
                    if (cnt_zero) begin
                        state_q <= EPULSE;
                        e_q     <= 1'b1;
                        cnt_q   <= LD_EPULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                EPULSE: begin
                    if (cnt_zero) begin
                        state_q <= HOLD;
                        e_q     <= 1'b0;
                        cnt_q   <= LD_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state_q <= EXEC_WAIT;
                        cnt_q   <= long_exec ? LD_LONG : LD_EXEC;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                EXEC_WAIT: begin
                    if (cnt_zero) begin
                        cnt_q <= '0;
                        if (!init_done_q && idx_q != 2'd3) begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= INIT_LOAD;
                        end else begin
                            init_done_q <= 1'b1;
                            ready_q     <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_valid && ready_q) begin
                        rs_q    <= cmd_rs;
                        db_q    <= cmd_data;
                        ready_q <= 1'b0;
                        state_q <= SETUP;
                        cnt_q   <= LD_SETUP;
                    end
                end
                default: begin
                    state_q <= PWRUP_WAIT;
                    cnt_q   <= LD_PWRUP;
                    ready_q <= 1'b0;
                    e_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmodclp_lcd_driver.sv
// Bench for pmodclp_lcd_driver: schedule-based reference model compared every cycle,
// plus literal timing pins for power-up, data, long instructions, streaming and reset.
module tb_pmodclp_lcd_driver;
    localparam int TP = 100;
    localparam int TS = 2;
    localparam int TE = 4;
    localparam int TH = 2;
    localparam int TX = 10;
    localparam int TL = 50;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;

    always #5 ACLK = ~ACLK;

    pmodclp_lcd_driver #(
        .T_POWERUP(TP), .T_SETUP(TS), .T_EPULSE(TE),
        .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TL)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rs(cmd_rs), .cmd_data(cmd_data),
        .init_done(init_done),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model: each write is described by its start edge and end edge.
    logic       m_rs = 1'b0;
    logic [7:0] m_db = 8'h00;
    logic       m_ready = 1'b0;
    logic       m_init_done = 1'b0;
    int         m_n = -1000;
    int         m_end = -1000;
    int         m_idx = 0;
    int         m_next_init = -1000;
    int         m_rst = 0;

    // Observed event log.
    logic [7:0] pq_db[$];
    logic       pq_rs[$];
    int         pw[$];
    int         rise_edge = 0;
    int         fall_edge = 0;
    int         rdy_edge = 0;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic int texec(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? TL : TX;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Model update on every rising edge using the inputs the DUT sees.
    initial begin
        forever begin
            @(posedge ACLK);
            cyc++;
            if (ARESET) begin
                m_rs = 1'b0; m_db = 8'h00; m_ready = 1'b0; m_init_done = 1'b0;
                m_n = -1000; m_end = -1000; m_idx = 0;
                m_rst = cyc; m_next_init = cyc + TP + 1;
            end else begin
                if (!m_init_done && cyc == m_next_init) begin
                    m_rs = 1'b0; m_db = init_byte(m_idx); m_n = cyc;
                    m_end = cyc + TS + TE + TH + texec(1'b0, m_db);
                end else if (m_ready && cmd_valid) begin
                    m_rs = cmd_rs; m_db = cmd_data; m_n = cyc;
                    m_end = cyc + TS + TE + TH + texec(cmd_rs, cmd_data);
                end
                if (cyc == m_end && !m_init_done) begin
                    if (m_idx == 3) m_init_done = 1'b1;
                    else begin
                        m_idx++;
                        m_next_init = cyc + 1;
                    end
                end
                m_ready = m_init_done && (cyc >= m_end);
            end
        end
    end

    // Per-cycle comparison and event logging, on the falling edge.
    initial begin
        logic prev_e;
        logic prev_rdy;
        logic exp_e;
        prev_e = 1'b0;
        prev_rdy = 1'b0;
        forever begin
            @(negedge ACLK);
            if (cyc > 0) begin
                exp_e = (cyc >= m_n + TS) && (cyc < m_n + TS + TE);
                checks++;
                if ({lcd_rs, lcd_rw, lcd_e, lcd_db, cmd_ready, init_done} !==
                    {m_rs, 1'b0, exp_e, m_db, m_ready, m_init_done}) begin
                    fails++;
                    $display("FAIL cycle %0d outputs: rs=%b rw=%b e=%b db=%h rdy=%b done=%b, expected rs=%b rw=0 e=%b db=%h rdy=%b done=%b",
                             cyc, lcd_rs, lcd_rw, lcd_e, lcd_db, cmd_ready, init_done,
                             m_rs, exp_e, m_db, m_ready, m_init_done);
                end
                if (lcd_e && !prev_e) begin
                    rise_edge = cyc;
                    pq_db.push_back(lcd_db);
                    pq_rs.push_back(lcd_rs);
                end
                if (!lcd_e && prev_e) begin
                    fall_edge = cyc;
                    pw.push_back(cyc - rise_edge);
                end
                if (cmd_ready && !prev_rdy) rdy_edge = cyc;
                prev_e = lcd_e;
                prev_rdy = cmd_ready;
            end
        end
    end

    task automatic wait_ready(input string name);
        int i;
        i = 0;
        while (!cmd_ready && i < 300) begin
            @(negedge ACLK); #2;
            i++;
        end
        if (!cmd_ready) begin
            checks++; fails++;
            $display("FAIL %s: cmd_ready timeout, got 0 expected 1", name);
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input logic keep, output int acc);
        int i;
        cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
        i = 0;
        while (!cmd_ready && i < 300) begin
            @(negedge ACLK); #2;
            i++;
        end
        if (!cmd_ready) begin
            checks++; fails++;
            $display("FAIL send_timeout: cmd_ready got 0 expected 1");
        end
        @(posedge ACLK); #1;
        acc = cyc;
        if (!keep) cmd_valid = 1'b0;
    endtask

    // Waits for init completion and pins the init sequence against literal values.
    task automatic check_init(input string tag);
        int i;
        i = 0;
        while (!init_done && i < 400) begin
            @(negedge ACLK); #2;
            i++;
        end
        chk({tag, "_done_edge"}, cyc - m_rst, 216);
        chk({tag, "_ready"}, int'(cmd_ready), 1);
        chk({tag, "_pulses"}, pq_db.size(), 4);
        if (pq_db.size() == 4 && pw.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk({tag, "_db"}, int'(pq_db[k]), int'(init_byte(k)));
                chk({tag, "_rs"}, int'(pq_rs[k]), 0);
                chk({tag, "_width"}, pw[k], 4);
            end
        end
    endtask

    initial begin
        int n;
        int a1;
        int a2;
        int gap;
        logic rs;
        logic keep;
        logic [7:0] d;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK); #2;
        chk("rst_e", int'(lcd_e), 0);
        chk("rst_db", int'(lcd_db), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_done", int'(init_done), 0);

        // Power-up with early host traffic pending the whole time.
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        pq_db.delete(); pq_rs.delete(); pw.delete();
        cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
        check_init("pwrup");
        @(posedge ACLK); #1;
        chk("early_accept_edge", cyc - m_rst, 217);
        cmd_valid = 1'b0;
        wait_ready("early");

        // Data write timing.
        send(1'b1, 8'h41, 1'b0, n);
        @(negedge ACLK); #2;
        chk("data_rs", int'(lcd_rs), 1);
        chk("data_db", int'(lcd_db), 8'h41);
        wait_ready("data");
        chk("data_ready_edge", rdy_edge - n, 18);
        chk("data_e_rise", rise_edge - n, 2);
        chk("data_e_fall", fall_edge - n, 6);

        // Long versus short execution of 0x01.
        send(1'b0, 8'h01, 1'b0, n);
        wait_ready("clear");
        chk("clear_ready_edge", rdy_edge - n, 58);
        send(1'b1, 8'h01, 1'b0, n);
        wait_ready("data01");
        chk("data01_ready_edge", rdy_edge - n, 18);

        // Back-to-back with valid held.
        send(1'b1, 8'h48, 1'b1, a1);
        send(1'b1, 8'h49, 1'b0, a2);
        chk("b2b_gap", a2 - a1, 19);
        wait_ready("b2b");

        // Randomized traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 25; k++) begin
            rs = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
            keep = 1'($urandom_range(0, 1));
            send(rs, d, keep, n);
            if (!keep) begin
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge ACLK);
                #2;
            end
        end
        cmd_valid = 1'b0;
        @(negedge ACLK); #2;
        wait_ready("random");

        // Reset in the middle of an E pulse.
        send(1'b1, 8'h80, 1'b0, n);
        begin
            int i;
            i = 0;
            while (!lcd_e && i < 20) begin
                @(negedge ACLK); #2;
                i++;
            end
        end
        chk("midrst_e_seen", int'(lcd_e), 1);
        ARESET = 1'b1;
        @(negedge ACLK); #2;
        chk("midrst_e", int'(lcd_e), 0);
        chk("midrst_db", int'(lcd_db), 0);
        chk("midrst_done", int'(init_done), 0);
        chk("midrst_ready", int'(cmd_ready), 0);
        pq_db.delete(); pq_rs.delete(); pw.delete();
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        check_init("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
